vit_dec_arb: RTL and testbench
==============================

# vit_dec_arb

Two-port round-robin arbiter and sequencer that shares one `viterbi_decoder` instance between two requesters. It accepts 16-bit coded words over valid/ready, launches the decoder with a single `en` pulse, waits for `done_flag` under a timeout, and returns the 8-bit decoded byte (or an error) to the requester that owns the transaction. It sits directly in front of `viterbi_decoder`: it drives `en` and `data`, and observes `data_out` and `done_flag`.

## Interface
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the transaction is aborted; must be ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: requester has a coded word.
- `req0_data`, `req1_data` in 16: coded word.
- `req0_ready`, `req1_ready` out 1: word accepted when valid&ready.
- `rsp0_valid`, `rsp1_valid` out 1: response available.
- `rsp0_data`, `rsp1_data` out 8: decoded byte; 0x00 on error.
- `rsp0_err`, `rsp1_err` out 1: 1 = decoder timed out.
- `rsp0_ready`, `rsp1_ready` in 1: response consumed when valid&ready.
- `dec_en` out 1: one-cycle launch pulse to the decoder `en`.
- `dec_data` out 16: word to the decoder `data`; held stable from launch until the response is consumed.
- `dec_data_out` in 8: decoder `data_out`.
- `dec_done` in 1: decoder `done_flag`.
- `dec_abort` out 1: one-cycle pulse on timeout; ORed into the decoder reset at top level.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states and transitions:
  - IDLE → START on an accepted request.
  - START → WAIT unconditionally.
  - WAIT → RESP on `dec_done` or on timeout.
  - RESP → IDLE on rsp handshake of the owner.
- Grant in IDLE:
  - If only one `reqN_valid` is high, grant that requester.
  - If both are high, grant the requester ≠ `last`.
  - `reqN_ready` = (state==IDLE) && grant==N. This is combinational from the valids, and only one ready is ever high.
- On acceptance:
  - Latch the word into `dec_data` and record `owner`.
  - Update `last` to `owner`.
- START: `dec_en`=1 for exactly this cycle.
- WAIT:
  - `cnt` clears on entry and increments each cycle without `dec_done`.
  - On `dec_done`: latch `dec_data_out` as the response data, err=0.
  - Else, if `cnt`==TIMEOUT-1: response data=0x00, err=1, and pulse `dec_abort` in the next cycle.
  - `cnt` width is $clog2(TIMEOUT)+1.
- RESP:
  - Only `rsp<owner>_valid` is high; the other port's valid stays 0.
  - Data and err are held stable until handshake.
  - No new request is accepted until the handshake completes.
- `dec_done` outside WAIT is ignored.
- `dec_done` in the same cycle as the timeout condition: done wins, err=0.
- Reset values:
  - state=IDLE, `last`=1 (so requester 0 wins the first contention), `cnt`=0.
  - All valids, readies, `dec_en`, `dec_abort`, `busy` = 0.
  - `dec_data`=0, rsp data=0, err=0.
- Reset mid-transaction: return to the reset state next cycle; any in-flight transaction is dropped with no response.

## Timing
- Accept in cycle T:
  - T+1: `dec_en`=1.
  - T+2: first WAIT cycle.
  - `dec_done` in WAIT cycle W → `rsp_valid` at W+1.
- Minimum accept-to-response: 3 cycles.
- Maximum: TIMEOUT+2 cycles plus response backpressure.
- `dec_abort` is asserted in the first RESP cycle of a timed-out transaction.
- Next acceptance is possible in the cycle after the rsp handshake (one IDLE cycle between transactions).
- All outputs are registered except `reqN_ready`.

## Structure
- Package `vit_sched_pkg`:
  - state enum (IDLE, START, WAIT, RESP)
  - coded/decoded width constants (16, 8)
  - default TIMEOUT
- Sub-module `rr_arb2`: combinational 2-way grant from valids and `last`.
- The FSM, counter and response registers live in `vit_dec_arb`.

## Test plan
- Single request: req0 word 0x1234; decoder returns 0xA5 with `dec_done` 5 cycles after `dec_en`. Required:
  - exactly one `dec_en` pulse with `dec_data`=0x1234
  - rsp0 0xA5, err=0, 1 cycle after done
  - rsp1 never valid
- Contention: both valid after reset (req0 0x1111, req1 0x2222). Required:
  - req0 served first, then req1
  - with both kept valid, the grant order alternates 0,1,0,1
- Timeout, TIMEOUT=8, `dec_done` never asserted. Required:
  - rsp err=1, data 0x00, 10 cycles after accept
  - one `dec_abort` pulse
- Done/timeout collision, TIMEOUT=8: `dec_done` on WAIT cycle 8 (`cnt`=7), `dec_data_out`=0x3C. Required:
  - err=0, data 0x3C
  - no `dec_abort`
- Backpressure: `rsp0_ready` low for 10 cycles while req1 is valid. Required:
  - rsp0 stable throughout
  - `req1_ready` stays 0 until the handshake, then req1 is accepted 1 cycle later
- Reset in WAIT, followed by a stray `dec_done`. Required:
  - every output at its reset value
  - no response generated
  - the next request proceeds normally

Source files
------------

// File: rtl/vit_sched_pkg.sv
// Shared types and constants for the two-port Viterbi decoder scheduler.
// Sequencer state encoding, datapath widths and the default WAIT timeout.
package vit_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int CODED_W         = 16;
  localparam int DECODED_W       = 8;
  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on contention
// the requester that was not served last wins.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = valid0 && (!valid1 || last);
    grant1 = valid1 && (!valid0 || !last);
  end

endmodule

// File: rtl/vit_dec_arb.sv
// Shares one viterbi_decoder between two requesters: round-robin accept,
// single-cycle launch, bounded wait for done, response back to the owner.
//
// Handshakes: a transfer happens in any cycle where valid and ready are both
// high at the rising edge; valid never depends on ready, and a raised rsp
// valid (with its data/err) is held unchanged until its transfer.
module vit_dec_arb
  import vit_sched_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  input  logic [CODED_W-1:0]   req0_data,
  input  logic [CODED_W-1:0]   req1_data,
  output logic                 req0_ready,
  output logic                 req1_ready,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [DECODED_W-1:0] rsp0_data,
  output logic [DECODED_W-1:0] rsp1_data,
  output logic                 rsp0_err,
  output logic                 rsp1_err,
  input  logic                 rsp0_ready,
  input  logic                 rsp1_ready,
  output logic                 dec_en,
  output logic [CODED_W-1:0]   dec_data,
  input  logic [DECODED_W-1:0] dec_data_out,
  input  logic                 dec_done,
  output logic                 dec_abort,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t               state, state_next;
  logic                 last, owner;
  logic [CNT_W-1:0]     cnt;
  logic [DECODED_W-1:0] rsp_data;
  logic                 rsp_err;
  logic                 grant0, grant1;
  logic                 accept, rsp_hs, timed_out;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  always_comb begin
    accept     = (state == IDLE) && (grant0 || grant1);
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
    rsp_hs     = owner ? rsp1_ready : rsp0_ready;
    timed_out  = (cnt == CNT_LAST);
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (dec_done || timed_out) state_next = RESP;
      RESP:    if (rsp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      dec_en     <= 1'b0;
      dec_abort  <= 1'b0;
      busy       <= 1'b0;
      dec_data   <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != IDLE);
      dec_en    <= accept;
      dec_abort <= 1'b0;
      if (accept) begin
        dec_data <= grant1 ? req1_data : req0_data;
        owner    <= grant1;
        last     <= grant1;
      end
      if (state == START) cnt <= '0;
      if (state == WAIT) begin
        // done takes priority over a timeout landing in the same cycle
        if (dec_done) begin
          rsp_data   <= dec_data_out;
          rsp_err    <= 1'b0;
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
        end else if (timed_out) begin
          rsp_data   <= '0;
          rsp_err    <= 1'b1;
          dec_abort  <= 1'b1;
          rsp0_valid <= !owner;
          rsp1_valid <= owner;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if ((state == RESP) && rsp_hs) begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
      end
    end
  end

  assign rsp0_data = rsp_data;
  assign rsp1_data = rsp_data;
  assign rsp0_err  = rsp_err;
  assign rsp1_err  = rsp_err;
  assign dbg_state = state;

endmodule

// File: tb/tb_vit_dec_arb.sv
// Directed bench for vit_dec_arb with a behavioural decoder responder.
module tb_vit_dec_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [7:0]  rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic        dec_en;
  logic [15:0] dec_data;
  logic [7:0]  dec_data_out = '0;
  logic        dec_done = 0;
  logic        dec_abort;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int dec_delay = 0;
  int pend = 0;
  logic [7:0] dec_word = '0;
  int en_cnt = 0, abort_cnt = 0, rsp1_seen = 0;
  logic [7:0] exp_q[$];

  vit_dec_arb #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .dec_en(dec_en), .dec_data(dec_data),
    .dec_data_out(dec_data_out), .dec_done(dec_done),
    .dec_abort(dec_abort), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; afterwards update monitors and the decoder responder model.
  task automatic tick();
    @(posedge clk);
    #1;
    dec_done = 1'b0;
    if (rst) pend = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        dec_done     = 1'b1;
        dec_data_out = dec_word;
      end
    end
    if (dec_en && dec_delay > 0) pend = dec_delay;
    en_cnt    += int'(dec_en);
    abort_cnt += int'(dec_abort);
    rsp1_seen += int'(rsp1_valid);
  endtask

  // Accept tick plus ticks until a response appears; n counts ticks from accept.
  task automatic accept_and_wait(output int n);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 1;
    while (!(rsp0_valid || rsp1_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("rsp_timeout_bound", 32'(n), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp0_valid"}, 32'(rsp0_valid), 0);
    check({tag, "_rsp1_valid"}, 32'(rsp1_valid), 0);
    check({tag, "_dec_en"}, 32'(dec_en), 0);
    check({tag, "_dec_abort"}, 32'(dec_abort), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_dec_data"}, 32'(dec_data), 0);
    check({tag, "_rsp_data"}, 32'(rsp0_data), 0);
    check({tag, "_rsp_err"}, 32'(rsp0_err), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  task automatic handshake(input bit port);
    if (port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check("hs_valid_drop", 32'(rsp0_valid | rsp1_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] exp_b;
    logic [7:0] hold_d;

    // reset
    do_reset();
    check_reset_outputs("reset");
    check("reset_req0_ready", 32'(req0_ready), 0);

    // single request
    en_cnt = 0; rsp1_seen = 0;
    dec_delay = 5; dec_word = 8'hA5;
    req0_data = 16'h1234; req0_valid = 1'b1;
    #1;
    check("single_req0_ready", 32'(req0_ready), 1);
    check("single_req1_ready", 32'(req1_ready), 0);
    tick();
    check("single_dec_en", 32'(dec_en), 1);
    check("single_dec_data", 32'(dec_data), 32'h1234);
    check("single_busy", 32'(busy), 1);
    req0_valid = 1'b0;
    n = 1;
    while (!(rsp0_valid || rsp1_valid) && n < 200) begin tick(); n++; end
    check("single_latency", 32'(n), 7);
    check("single_rsp0_valid", 32'(rsp0_valid), 1);
    check("single_rsp0_data", 32'(rsp0_data), 32'hA5);
    check("single_rsp0_err", 32'(rsp0_err), 0);
    check("single_dec_data_hold", 32'(dec_data), 32'h1234);
    handshake(0);
    tick();
    check("single_en_count", 32'(en_cnt), 1);
    check("single_rsp1_never", 32'(rsp1_seen), 0);
    check("single_idle_busy", 32'(busy), 0);

    // contention with both kept valid: order 0,1,0,1
    do_reset();
    dec_delay = 2;
    req0_data = 16'h1111; req1_data = 16'h2222;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_ready0", 32'(req0_ready), 32'((i % 2) == 0));
      check("cont_ready1", 32'(req1_ready), 32'((i % 2) == 1));
      dec_word = 8'h10 + 8'(i);
      exp_q.push_back(8'h10 + 8'(i));
      tick();
      check("cont_dec_data", 32'(dec_data), (i % 2) ? 32'h2222 : 32'h1111);
      n = 1;
      while (!(rsp0_valid || rsp1_valid) && n < 200) begin tick(); n++; end
      check("cont_latency", 32'(n), 4);
      check("cont_rsp0_valid", 32'(rsp0_valid), 32'((i % 2) == 0));
      check("cont_rsp1_valid", 32'(rsp1_valid), 32'((i % 2) == 1));
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      check("cont_rsp_data", 32'((i % 2) ? rsp1_data : rsp0_data), 32'(exp_b));
      handshake(i[0]);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // timeout
    abort_cnt = 0;
    dec_delay = 0;
    req0_data = 16'hBEEF; req0_valid = 1'b1;
    #1;
    accept_and_wait(n);
    check("to_latency", 32'(n), 10);
    check("to_rsp0_valid", 32'(rsp0_valid), 1);
    check("to_err", 32'(rsp0_err), 1);
    check("to_data", 32'(rsp0_data), 0);
    check("to_abort_now", 32'(dec_abort), 1);
    tick();
    tick();
    check("to_abort_count", 32'(abort_cnt), 1);
    check("to_rsp_held", 32'(rsp0_valid), 1);
    handshake(0);
    tick();

    // done on the last WAIT cycle
    abort_cnt = 0;
    dec_delay = 8; dec_word = 8'h3C;
    req1_data = 16'h0F0F; req1_valid = 1'b1;
    #1;
    accept_and_wait(n);
    check("col_latency", 32'(n), 10);
    check("col_rsp1_valid", 32'(rsp1_valid), 1);
    check("col_err", 32'(rsp1_err), 0);
    check("col_data", 32'(rsp1_data), 32'h3C);
    handshake(1);
    tick();
    check("col_abort_count", 32'(abort_cnt), 0);

    // response backpressure with req1 waiting
    dec_delay = 2; dec_word = 8'h81;
    req0_data = 16'hAAAA; req0_valid = 1'b1;
    #1;
    accept_and_wait(n);
    hold_d = rsp0_data;
    check("bp_first_data", 32'(hold_d), 32'h81);
    req1_data = 16'h5555; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_req1_ready", 32'(req1_ready), 0);
      check("bp_rsp0_valid", 32'(rsp0_valid), 1);
      check("bp_rsp0_data", 32'(rsp0_data), 32'(hold_d));
      tick();
    end
    dec_word = 8'h99;
    handshake(0);
    check("bp_req1_ready_after", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    check("bp_req1_dec_en", 32'(dec_en), 1);
    check("bp_req1_dec_data", 32'(dec_data), 32'h5555);
    n = 1;
    while (!(rsp0_valid || rsp1_valid) && n < 200) begin tick(); n++; end
    check("bp_req1_rsp", 32'(rsp1_data), 32'h99);
    handshake(1);
    tick();

    // reset while in WAIT, then a stray done
    dec_delay = 0;
    req0_data = 16'hCAFE; req0_valid = 1'b1;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    check("rw_in_wait", 32'(dbg_state), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rw");
    dec_done = 1'b1; dec_data_out = 8'h77;
    tick();
    tick();
    tick();
    check("rw_no_rsp", 32'(rsp0_valid | rsp1_valid), 0);
    check("rw_idle_busy", 32'(busy), 0);
    dec_delay = 3; dec_word = 8'h42;
    req0_data = 16'h0042; req0_valid = 1'b1;
    #1;
    check("rw_next_ready", 32'(req0_ready), 1);
    accept_and_wait(n);
    check("rw_next_latency", 32'(n), 5);
    check("rw_next_data", 32'(rsp0_data), 32'h42);
    check("rw_next_err", 32'(rsp0_err), 0);
    handshake(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
